inv_sub_bytes: RTL and testbench
================================

# inv_sub_bytes

Pipelined AES InvSubBytes unit for the decrypt datapath: accepts one 128-bit state over a valid/ready handshake and returns the state with every byte replaced by its inverse S-box value. Four lanes of a pipelined composite-field inverse S-box process one state column per cycle, so a block takes four feed beats. It sits between the decrypt round-key XOR and InvMixColumns, and mirrors the forward S-box used on the encrypt side.

## Interface
- `LAT`, 6: inverse S-box pipeline depth in cycles; fixed by the sub-module.
- `clk  input  1`: single clock; all state changes on the rising edge.
- `rst  input  1`: synchronous, active-low reset (0 = reset).
- `in_state  input  128`: input state; byte k = `in_state[127-8k -: 8]`; column-major, so byte k is row k%4, column k/4.
- `in_valid  input  1`: `in_state` is valid.
- `in_ready  output  1`: block can accept; high only in IDLE while `rst`=1.
- `out_state  output  128`: result, same byte ordering.
- `out_valid  output  1`: `out_state` is valid; held until accepted.
- `out_ready  input  1`: downstream accepts.

## Operation
- FSM states and transitions:
  - IDLE: wait for input.
  - FEED: 4 beats.
  - DRAIN: wait for pipeline results.
  - HOLD: present result.
- IDLE -> FEED on `in_valid && in_ready`. `in_state` is captured into the input register and the feed counter is cleared.
- FEED: beat b (b = 0..3) drives bytes 4b..4b+3 (column b) into lanes 0..3 and raises a tag bit. After beat 3, go to DRAIN.
- Tag pipeline: a LAT-deep shift register runs in parallel with the lanes. When the tag emerges, lane outputs are written to column `wr_cnt` of the output register and `wr_cnt` increments.
- DRAIN -> HOLD when the fourth column is written. `out_valid` goes high in HOLD.
- HOLD -> IDLE on `out_valid && out_ready`.
- `in_ready` is low in FEED, DRAIN and HOLD. Only one block is in flight at a time.
- `out_state` is stable while `out_valid` is high and not accepted.
- Inverse S-box per byte: inverse affine transform, then inversion in GF(2^8) via the GF((2^4)^2) composite field, then the inverse isomorphic map. There is no 0x05 constant XOR on the output side; the affine constant 0x63 is removed on the input side.
- Reset values: state IDLE; `out_state`=0, `out_valid`=0, `in_ready`=0 while `rst`=0. The feed counter, `wr_cnt` and all tag bits are 0. Lane registers are cleared to 0.
- Reset mid-operation: the in-flight block is discarded. No partial result is ever presented. The first accept after reset is clean, because the tag pipeline is cleared and stale lane data is never written.
- `in_valid` during non-IDLE states is ignored; no data is lost, because the source holds until `in_ready`.

## Timing
- Let E be the edge accepting the input.
- Beat b is sampled by the lanes at edge E+1+b.
- Column b is written at edge E+1+b+LAT.
- `out_valid` is high from the cycle after E+10 (LAT=6).
- With `out_ready` held high: output handshake at E+11, `in_ready` high after E+11, next accept at E+12. Sustained throughput is one block per 12 cycles.
- `out_ready` low stalls in HOLD indefinitely with no change to outputs.

## Configuration
- `INV_SHIFT_ROWS_EN` defined: the input register captures InvShiftRows(`in_state`), i.e. stored byte r+4c = input byte r+4((c-r) mod 4). The output is InvSubBytes(InvShiftRows(state)).
- With the macro: latency and handshake are unchanged, and no ports are added.
- Undefined: pure InvSubBytes.

## Structure
- Shared package `aes_pkg` holds:
  - `state_t` (logic [127:0]);
  - `byte_t`;
  - `LAT`;
  - FSM enum `inv_sb_state_e` {IDLE, FEED, DRAIN, HOLD};
  - the inverse isomorphic/affine constants.
- One sub-module, `inv_sbox`: an 8-bit pipelined inverse S-box with ports `clk`, `rst`, `x`, `y`, latency LAT. It reuses the GF(2^4) square, lambda-multiply, multiply and inverse primitives from the encrypt side, and is instantiated four times.

## Test plan
- All `in_state` bytes 0x63, `out_ready`=1 -> `out_state` all 0x00; `out_valid` rises exactly 10 cycles after accept.
- Bytes 0..3 = 0x63, 0x7C, 0xED, 0x16 (rest 0x63) -> bytes 0..3 = 0x00, 0x01, 0x53, 0xFF (rest 0x00).
- 64 back-to-back blocks covering all 256 byte values -> every byte matches the FIPS-197 inverse S-box table; accepts spaced 12 cycles apart.
- `out_ready` low for 20 cycles in HOLD -> `out_state`/`out_valid` stable, `in_ready`=0, pending `in_valid` not accepted; release -> one handshake.
- `rst`=0 asserted during DRAIN, then released -> `out_valid` stays 0; the next block's result is correct, with no stale columns.
- `INV_SHIFT_ROWS_EN` set, input byte k = S(k) -> output byte 1 = 0x0D, byte 5 = 0x01, byte 0 = 0x00.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decrypt-side types, FSM encoding, GF(2^4) primitives and the
// composite-field isomorphism constants used by the inverse S-box lanes.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;
    typedef logic [3:0]   nib_t;

    localparam int unsigned LAT = 6;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} inv_sb_state_e;

    localparam byte_t      INV_AFFINE_C = 8'h63;
    localparam nib_t       GF4_LAMBDA   = 4'hC;
    localparam logic [8:0] AES_POLY     = 9'h11B;

    // GF(2^4) over w^4 + w + 1
    function automatic nib_t gf4_mul(input nib_t a, input nib_t b);
        nib_t p;
        nib_t t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic nib_t gf4_sq(input nib_t a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    function automatic nib_t gf4_mul_lambda(input nib_t a);
        return gf4_mul(a, GF4_LAMBDA);
    endfunction

    // a^14 = a^-1 for a != 0, and 0 maps to 0
    function automatic nib_t gf4_inv(input nib_t a);
        nib_t s2;
        nib_t s4;
        nib_t s8;
        s2 = gf4_sq(a);
        s4 = gf4_sq(s2);
        s8 = gf4_sq(s4);
        return gf4_mul(gf4_mul(s2, s4), s8);
    endfunction

    // GF((2^4)^2) over z^2 + z + lambda, element {hi, lo}
    function automatic byte_t gf8c_mul(input byte_t a, input byte_t b);
        nib_t hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul_lambda(hh) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    function automatic byte_t iso_apply(input logic [63:0] cols, input byte_t a);
        byte_t r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (a[i]) r = r ^ cols[8*i +: 8];
        end
        return r;
    endfunction

    // Columns are powers of a composite-field root of the AES polynomial,
    // so x^i -> beta^i is a field isomorphism by construction.
    function automatic logic [63:0] calc_iso_fwd();
        byte_t      root;
        byte_t      p;
        byte_t      acc;
        logic [63:0] cols;
        root = '0;
        for (int unsigned c = 2; c < 256; c++) begin
            p   = 8'h01;
            acc = '0;
            for (int unsigned i = 0; i < 9; i++) begin
                if (AES_POLY[i]) acc = acc ^ p;
                p = gf8c_mul(p, byte_t'(c));
            end
            if (acc == '0 && root == '0) root = byte_t'(c);
        end
        p    = 8'h01;
        cols = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cols[8*i +: 8] = p;
            p = gf8c_mul(p, root);
        end
        return cols;
    endfunction

    function automatic logic [63:0] calc_iso_inv(input logic [63:0] fwd);
        logic [63:0] cols;
        byte_t       d;
        cols = '0;
        for (int unsigned a = 0; a < 256; a++) begin
            d = iso_apply(fwd, byte_t'(a));
            for (int unsigned j = 0; j < 8; j++) begin
                if (d == byte_t'(1 << j)) cols[8*j +: 8] = byte_t'(a);
            end
        end
        return cols;
    endfunction

    localparam logic [63:0] ISO_FWD = calc_iso_fwd();
    localparam logic [63:0] ISO_INV = calc_iso_inv(ISO_FWD);

endpackage

// File: rtl/inv_sub_bytes_inv_sbox.sv
// Six-stage pipelined AES inverse S-box: inverse affine, composite-field
// inversion in GF((2^4)^2), inverse isomorphic map back to the AES basis.
module inv_sbox
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    output logic [7:0] y
);

    byte_t r_x;
    byte_t r_iso;
    nib_t  r_h3;
    nib_t  r_l3;
    nib_t  r_sq3;
    nib_t  r_pr3;
    nib_t  r_h4;
    nib_t  r_l4;
    nib_t  r_inv4;
    byte_t r_mul5;
    byte_t r_y;

    byte_t w_v;
    byte_t w_aff;

    // 0x63 stripped first, so the remaining inverse affine map is purely linear
    always_comb begin
        w_v   = r_x ^ INV_AFFINE_C;
        w_aff = {w_v[6:0], w_v[7]} ^ {w_v[4:0], w_v[7:5]} ^ {w_v[1:0], w_v[7:2]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x    <= '0;
            r_iso  <= '0;
            r_h3   <= '0;
            r_l3   <= '0;
            r_sq3  <= '0;
            r_pr3  <= '0;
            r_h4   <= '0;
            r_l4   <= '0;
            r_inv4 <= '0;
            r_mul5 <= '0;
            r_y    <= '0;
        end else begin
            r_x    <= x;
            r_iso  <= iso_apply(ISO_FWD, w_aff);
            r_h3   <= r_iso[7:4];
            r_l3   <= r_iso[3:0];
            r_sq3  <= gf4_mul_lambda(gf4_sq(r_iso[7:4]));
            r_pr3  <= gf4_mul(r_iso[7:4] ^ r_iso[3:0], r_iso[3:0]);
            r_h4   <= r_h3;
            r_l4   <= r_l3;
            r_inv4 <= gf4_inv(r_sq3 ^ r_pr3);
            r_mul5 <= {gf4_mul(r_h4, r_inv4), gf4_mul(r_h4 ^ r_l4, r_inv4)};
            r_y    <= iso_apply(ISO_INV, r_mul5);
        end
    end

    assign y = r_y;

endmodule

// File: rtl/inv_sub_bytes.sv
// Column-serial AES InvSubBytes over a valid/ready handshake, one block in flight.
// Define INV_SHIFT_ROWS_EN to fold InvShiftRows into the input capture.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready
);

    inv_sb_state_e  r_state;
    logic [31:0]    r_in_col  [4];
    logic [31:0]    r_out_col [4];
    logic [1:0]     r_feed_cnt;
    logic [1:0]     r_wr_cnt;
    logic [LAT-1:0] r_tag;
    logic           r_out_valid;

    state_t      w_cap;
    logic        w_feed;
    logic        w_tag_out;
    logic [31:0] w_col;
    logic [31:0] w_res_col;

    always_comb begin
        w_cap = in_state;
`ifdef INV_SHIFT_ROWS_EN
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                w_cap[127 - 8*(r + 4*c) -: 8] = in_state[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
`endif
    end

    assign w_feed    = (r_state == FEED);
    assign w_tag_out = r_tag[LAT-1];
    assign w_col     = w_feed ? r_in_col[r_feed_cnt] : '0;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .clk (clk),
            .rst (rst),
            .x   (w_col[31 - 8*g -: 8]),
            .y   (w_res_col[31 - 8*g -: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_feed_cnt  <= '0;
            r_wr_cnt    <= '0;
            r_tag       <= '0;
            r_out_valid <= 1'b0;
            for (int unsigned c = 0; c < 4; c++) begin
                r_in_col[c]  <= '0;
                r_out_col[c] <= '0;
            end
        end else begin
            r_tag <= {r_tag[LAT-2:0], w_feed};
            // The tag marks a lane result from this block; lanes otherwise carry don't-care data
            if (w_tag_out) begin
                r_out_col[r_wr_cnt] <= w_res_col;
                r_wr_cnt            <= r_wr_cnt + 2'd1;
            end
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned c = 0; c < 4; c++) begin
                            r_in_col[c] <= w_cap[127 - 32*c -: 32];
                        end
                        r_feed_cnt <= '0;
                        r_state    <= FEED;
                    end
                end
                FEED: begin
                    r_feed_cnt <= r_feed_cnt + 2'd1;
                    if (r_feed_cnt == 2'd3) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_tag_out && r_wr_cnt == 2'd3) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && rst;
    assign out_valid = r_out_valid;
    assign out_state = {r_out_col[0], r_out_col[1], r_out_col[2], r_out_col[3]};

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench for inv_sub_bytes; expected blocks come from an
// arithmetic AES S-box model built at time zero.
module tb_inv_sub_bytes;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_state;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    byte_t       fsb [256];
    byte_t       isb [256];
    state_t      sb [$];

    inv_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_state  (in_state),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_state (out_state),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic byte_t rotl(input byte_t v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        byte_t inv;
        byte_t s;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++) begin
                if (gmul(byte_t'(a), byte_t'(b)) == 8'h01) inv = byte_t'(b);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            fsb[a] = s;
            isb[s] = byte_t'(a);
        end
    endtask

    function automatic state_t model(input state_t s);
        state_t t;
        state_t r;
        t = s;
`ifdef INV_SHIFT_ROWS_EN
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                t[127 - 8*(rr + 4*c) -: 8] = s[127 - 8*(rr + 4*((c + 4 - rr) % 4)) -: 8];
            end
        end
`endif
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = isb[t[127 - 8*k -: 8]];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input state_t s, output int unsigned acc_cyc, output bit ok);
        in_state = s;
        in_valid = 1'b1;
        ok       = 1'b0;
        acc_cyc  = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (in_ready) begin
                acc_cyc = cyc + 1;
                ok      = 1'b1;
                sb.push_back(model(s));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Returns at the first negedge with out_valid high, without consuming it.
    task automatic recv(output state_t got, output int unsigned out_cyc, output bit ok);
        ok      = 1'b0;
        got     = '0;
        out_cyc = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (out_valid) begin
                got     = out_state;
                out_cyc = cyc;
                ok      = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h want 0", out_state); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_all_63();
        int unsigned acc, oc;
        bit          ok;
        state_t      got, exp;
        send({16{8'h63}}, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL all63_accept: got timeout want accept"); return; end
        recv(got, oc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL all63_output: got timeout want out_valid"); return; end
        checks++;
        if (oc - acc != 10) begin errors++; $display("FAIL all63_latency: got %0d want 10", oc - acc); end
        checks++;
        if (got !== 128'h0) begin errors++; $display("FAIL all63_const: got %h want 0", got); end
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL all63_sb: got %h want %h", got, exp); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL all63_handshake: got out_valid %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL all63_idle_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_known_bytes();
        int unsigned acc, oc;
        bit          ok;
        state_t      got, exp;
        send({8'h63, 8'h7C, 8'hED, 8'h16, {12{8'h63}}}, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL known_accept: got timeout want accept"); return; end
        recv(got, oc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL known_output: got timeout want out_valid"); return; end
`ifndef INV_SHIFT_ROWS_EN
        checks++;
        if (got !== {8'h00, 8'h01, 8'h53, 8'hFF, 96'h0}) begin
            errors++; $display("FAIL known_const: got %h want 000153ff followed by zeros", got);
        end
`endif
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL known_sb: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        fork
            begin : driver
                int unsigned acc, prev;
                bit          ok;
                state_t      s;
                prev = 0;
                for (int i = 0; i < 64; i++) begin
                    for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = byte_t'((i * 16 + k) % 256);
                    send(s, acc, ok);
                    checks++;
                    if (!ok) begin errors++; $display("FAIL b2b_accept[%0d]: got timeout want accept", i); break; end
                    if (i > 0) begin
                        checks++;
                        if (acc - prev != 12) begin
                            errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 12", i, acc - prev);
                        end
                    end
                    prev = acc;
                end
            end
            begin : collector
                int unsigned oc;
                bit          ok;
                state_t      got, exp;
                for (int i = 0; i < 64; i++) begin
                    recv(got, oc, ok);
                    checks++;
                    if (!ok || sb.size() == 0) begin
                        errors++; $display("FAIL b2b_output[%0d]: got timeout or empty scoreboard want block", i); break;
                    end
                    exp = sb.pop_front();
                    checks++;
                    if (got !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got, exp); end
                    @(negedge clk);
                end
            end
        join
        sb.delete();
    endtask

    task automatic test_hold_stall();
        int unsigned acc, oc;
        bit          ok;
        state_t      got, exp, held;
        out_ready = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom}, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_accept: got timeout want accept"); out_ready = 1'b1; return; end
        recv(got, oc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_output: got timeout want out_valid"); out_ready = 1'b1; return; end
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stall_data: got %h want %h", got, exp); end
        held     = got;
        in_state = {4{32'hA5C3_0F1E}};
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", n, out_valid); end
            checks++;
            if (out_state !== held) begin errors++; $display("FAIL stall_state[%0d]: got %h want %h", n, out_state, held); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", n, in_ready); end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got out_valid %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_single_handshake: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int unsigned acc, oc;
        bit          ok;
        state_t      got, exp;
        send({16{8'hC7}}, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_accept_a: got timeout want accept"); return; end
        for (int n = 0; n < 20 && cyc < acc + 8; n++) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_state !== 128'h0) begin errors++; $display("FAIL rstmid_state: got %h want 0", out_state); end
        sb.delete();
        rst = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial[%0d]: got %b want 0", n, out_valid); end
        end
        send({32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210}, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_accept_b: got timeout want accept"); return; end
        recv(got, oc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_output_b: got timeout want out_valid"); return; end
        checks++;
        if (oc - acc != 10) begin errors++; $display("FAIL rstmid_latency: got %0d want 10", oc - acc); end
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rstmid_data_b: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    task automatic test_shift_pattern();
        int unsigned acc, oc;
        bit          ok;
        state_t      s, got, exp;
        for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = fsb[k];
        send(s, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sr_accept: got timeout want accept"); return; end
        recv(got, oc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sr_output: got timeout want out_valid"); return; end
`ifdef INV_SHIFT_ROWS_EN
        checks++;
        if (got[119:112] !== 8'h0D) begin errors++; $display("FAIL sr_byte1: got %h want 0d", got[119:112]); end
        checks++;
        if (got[87:80] !== 8'h01) begin errors++; $display("FAIL sr_byte5: got %h want 01", got[87:80]); end
`else
        checks++;
        if (got[119:112] !== 8'h01) begin errors++; $display("FAIL sr_byte1: got %h want 01", got[119:112]); end
        checks++;
        if (got[87:80] !== 8'h05) begin errors++; $display("FAIL sr_byte5: got %h want 05", got[87:80]); end
`endif
        checks++;
        if (got[127:120] !== 8'h00) begin errors++; $display("FAIL sr_byte0: got %h want 00", got[127:120]); end
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sr_sb: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        build_tables();
        @(negedge clk);
        test_reset();
        test_all_63();
        test_known_bytes();
        test_back_to_back();
        test_hold_stall();
        test_reset_mid();
        test_shift_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
